imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Sequencer and two-way arbiter for the byte-wide instruction memory. It shares the single 8-bit memory port between the instruction-fetch requester and the debug/program-loader requester. For each request it runs four byte accesses and returns one big-endian 32-bit word: byte at `addr` lands in `[31:24]`, byte at `addr+3` in `[7:0]`. It sits between the PC/fetch stage and the memory array, replacing direct combinational reads with a handshaked, registered path.

## Interface
- `ADDR_BITS`, 8, memory byte-address width (256 bytes at default).
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `f_req_valid` in 1: fetch read request.
- `f_req_ready` out 1: fetch request accepted this cycle.
- `f_req_addr` in 32: fetch byte address.
- `f_rsp_valid` out 1: one-cycle fetch response pulse.
- `f_rsp_data` out 32: fetched word.
- `f_rsp_err` out 1: fetch address error.
- `d_req_valid` in 1: debug request.
- `d_req_ready` out 1: debug request accepted.
- `d_req_addr` in 32: debug byte address.
- `d_req_we` in 1: 1 = write word, 0 = read word.
- `d_req_wdata` in 32: write word, big-endian.
- `d_rsp_valid` out 1: one-cycle debug response pulse.
- `d_rsp_data` out 32: read word; 0 for writes.
- `d_rsp_err` out 1: debug address error.
- `mem_addr` out ADDR_BITS: memory byte address.
- `mem_re` out 1: memory read enable.
- `mem_we` out 1: memory write enable.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: read byte, valid the cycle after `mem_re`.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - RD: issue four reads.
  - RDWAIT: capture the last byte.
  - WR: issue four writes.
  - RESP: drive the response.
- Ready is asserted only in IDLE, and only to the granted requester. It is combinational from the valid inputs and `last_grant`.
- Arbitration:
  - One requester valid: it is granted.
  - Both valid: round-robin. The requester not in `last_grant` wins. `last_grant` updates on each accept.
  - Reset value of `last_grant` is debug, so fetch wins the first tie.
- On accept, the block registers the base address (truncated to ADDR_BITS), requester id, `we` and `wdata`.
  - Read goes to RD; debug write goes to WR.
- Byte index counter `i` runs 0..3. `mem_addr = base + i`, modulo 2^ADDR_BITS, so 0xFE → 0xFE, 0xFF, 0x00, 0x01.
- RD:
  - `mem_re=1` for i=0..3.
  - The byte returned for index k is shifted into the word register one cycle later.
  - After i=3, go to RDWAIT.
  - RDWAIT captures byte 3, then go to RESP.
- WR: `mem_we=1`, `mem_wdata = wdata[31-8i -: 8]` for i=0..3, then RESP.
- RESP:
  - Asserts the owner's `rsp_valid` for exactly one cycle, with data/err held that cycle.
  - The other requester's response outputs stay 0.
  - Next state is IDLE.
- Responses have no back-pressure; the requester must take them.
- Reset values:
  - All outputs 0, state IDLE, counter 0, word register 0.
  - `mem_re`/`mem_we` are low in the cycle after reset is sampled.
- Reset mid-operation aborts the transaction with no response. Bytes already written stay written.

## Timing
- Accept at cycle T (valid && ready high at the edge ending T).
- Read:
  - `mem_re` high in T+1..T+4, addresses base..base+3.
  - Bytes captured at the ends of T+2..T+5.
  - `rsp_valid` in T+6 (latency 6).
  - Next accept no earlier than T+7.
- Write:
  - `mem_we` high in T+1..T+4.
  - `rsp_valid` in T+5.
  - Next accept no earlier than T+6.
- `mem_re` and `mem_we` are never high together.
- All outputs except `*_req_ready` are registered.

## Configuration
- `IMEM_ARB_ALIGN_CHK_EN` defined:
  - A request is an error if `addr[1:0]!=0` or any `addr[31:ADDR_BITS]` bit is set.
  - An erroring request does no memory access. It goes IDLE → RESP in T+1 with `rsp_err=1` and `rsp_data=0`.
- `IMEM_ARB_ALIGN_CHK_EN` undefined:
  - `*_rsp_err` is tied 0.
  - Upper address bits are dropped.
  - Unaligned addresses are read/written byte-wise with wrap.

## Test plan
- Fetch read, mem[0x10..0x13]=12,34,56,78: `f_req_addr=0x10` accepted at T → `mem_re` T+1..T+4 on 0x10..0x13; `f_rsp_valid` in T+6 with data 0x12345678, err 0.
- Debug write 0xDEADBEEF to 0x20, then fetch 0x20 → `mem_we` bytes DE,AD,BE,EF at 0x20..0x23, `d_rsp_valid` at T+5; fetch returns 0xDEADBEEF.
- Both valid continuously from reset → grants alternate F, D, F, D; first `f_rsp_valid` precedes first `d_rsp_valid`.
- Read at 0xFE, macro off → addresses FE, FF, 00, 01 and data assembled in that order; macro on → no `mem_re`, `f_rsp_err=1` at T+1.
- Macro on, `d_req_addr=0x100` → `d_rsp_err=1`, `d_rsp_data=0`, no `mem_we`.
- Reset asserted at T+3 of a debug write → no `d_rsp_valid`, `mem_we` low at T+4, FSM in IDLE, `f_req_ready` follows `f_req_valid` next cycle.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-way arbiter and byte sequencer for the 8-bit instruction memory port.
// Optional IMEM_ARB_ALIGN_CHK_EN flags unaligned / out-of-range requests as errors.
module imem_arbiter #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req_valid,
  output logic                 f_req_ready,
  input  logic [31:0]          f_req_addr,
  output logic                 f_rsp_valid,
  output logic [31:0]          f_rsp_data,
  output logic                 f_rsp_err,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [31:0]          d_req_addr,
  input  logic                 d_req_we,
  input  logic [31:0]          d_req_wdata,
  output logic                 d_rsp_valid,
  output logic [31:0]          d_rsp_data,
  output logic                 d_rsp_err,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDWAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t              state;
  logic                last_grant;  // 1 = debug was granted last
  logic                owner;       // 1 = debug owns the current transaction
  logic [1:0]          cnt;
  logic [31:0]         wbuf;
  logic [31:0]         word;
  logic                cap_en;

  logic                grant_f;
  logic                grant_d;
  logic                accept;
  logic                sel_we;
  logic                sel_err;
  logic [ADDR_BITS-1:0] sel_base;

  // Round-robin: on a tie the requester not granted last time wins.
  assign grant_f     = f_req_valid && (!d_req_valid || last_grant);
  assign grant_d     = d_req_valid && (!f_req_valid || !last_grant);
  assign f_req_ready = (state == S_IDLE) && grant_f;
  assign d_req_ready = (state == S_IDLE) && grant_d;
  assign accept      = f_req_ready || d_req_ready;
  assign sel_we      = grant_d && d_req_we;
  assign sel_base    = grant_d ? d_req_addr[ADDR_BITS-1:0] : f_req_addr[ADDR_BITS-1:0];

`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic [31:0] sel_addr;
  assign sel_addr = grant_d ? d_req_addr : f_req_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> ADDR_BITS) != 32'd0);
`else
  logic unused_upper_addr;
  assign sel_err           = 1'b0;
  assign unused_upper_addr = ^{f_req_addr, d_req_addr};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= 2'd0;
      wbuf        <= 32'd0;
      word        <= 32'd0;
      cap_en      <= 1'b0;
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= 32'd0;
      f_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= 32'd0;
      d_rsp_err   <= 1'b0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= 8'd0;
    end else begin
      // Read data returns one cycle after mem_re; shift it in big-endian order.
      cap_en <= mem_re;
      if (cap_en) word <= {word[23:0], mem_rdata};

      case (state)
        S_IDLE: begin
          if (accept) begin
            last_grant <= grant_d;
            owner      <= grant_d;
            mem_addr   <= sel_base;
            cnt        <= 2'd0;
            if (sel_err) begin
              state       <= S_RESP;
              f_rsp_valid <= !grant_d;
              f_rsp_err   <= !grant_d;
              d_rsp_valid <= grant_d;
              d_rsp_err   <= grant_d;
              f_rsp_data  <= 32'd0;
              d_rsp_data  <= 32'd0;
            end else if (sel_we) begin
              state     <= S_WR;
              mem_we    <= 1'b1;
              mem_wdata <= d_req_wdata[31:24];
              wbuf      <= {d_req_wdata[23:0], 8'h00};
            end else begin
              state  <= S_RD;
              mem_re <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (cnt == 2'd3) begin
            mem_re <= 1'b0;
            state  <= S_RDWAIT;
          end else begin
            mem_addr <= mem_addr + ADDR_BITS'(1);
            cnt      <= cnt + 2'd1;
          end
        end
        S_RDWAIT: begin
          state <= S_RESP;
          if (owner) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= {word[23:0], mem_rdata};
          end else begin
            f_rsp_valid <= 1'b1;
            f_rsp_data  <= {word[23:0], mem_rdata};
          end
        end
        S_WR: begin
          if (cnt == 2'd3) begin
            mem_we      <= 1'b0;
            state       <= S_RESP;
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= 32'd0;
          end else begin
            mem_addr  <= mem_addr + ADDR_BITS'(1);
            mem_wdata <= wbuf[31:24];
            wbuf      <= {wbuf[23:0], 8'h00};
            cnt       <= cnt + 2'd1;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          f_rsp_valid <= 1'b0;
          f_rsp_data  <= 32'd0;
          f_rsp_err   <= 1'b0;
          d_rsp_valid <= 1'b0;
          d_rsp_data  <= 32'd0;
          d_rsp_err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table, scoreboard of responses, and reset/arbitration sequences.
module tb_imem_arbiter;
  localparam int unsigned AB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [31:0]   f_req_addr, f_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [31:0]   d_req_addr, d_req_wdata, d_rsp_data;
  logic [AB-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;

  imem_arbiter #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          dbg;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         rsp_count = 0;
  int         d_rsp_count = 0;
  int         acc_cyc = 0;
  logic [31:0] last_data;
  bit          last_err;
  exp_t        sb[$];
  bit          grants[$];
  bit          rsp_order[$];
  acc_t        acc_log[$];
  vec_t        vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] b);
    return {ref_mem[b], ref_mem[8'(b + 8'd1)], ref_mem[8'(b + 8'd2)], ref_mem[8'(b + 8'd3)]};
  endfunction

  // Monitor: pops and checks responses, pushes expectations on each accept.
  always @(negedge clk) begin
    exp_t e;
    bit dbg, err, we;
    logic [31:0] addr;
    if (reset) begin
      sb.delete();
    end else begin
      chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
      chk("ready_exclusive", {31'd0, f_req_ready & d_req_ready}, 32'd0);
      if (mem_re || mem_we) acc_log.push_back('{cyc, mem_we, mem_addr, mem_wdata});
      if (f_rsp_valid || d_rsp_valid) begin
        rsp_count++;
        if (d_rsp_valid) d_rsp_count++;
        rsp_order.push_back(d_rsp_valid);
        last_data = d_rsp_valid ? d_rsp_data : f_rsp_data;
        last_err  = d_rsp_valid ? d_rsp_err : f_rsp_err;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", {31'd0, d_rsp_valid}, {31'd0, e.dbg});
          chk("rsp_data", last_data, e.data);
          chk("rsp_err", {31'd0, last_err}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.due);
          if (e.dbg) chk("fetch_rsp_quiet", {30'd0, f_rsp_valid, f_rsp_err} | f_rsp_data, 32'd0);
          else       chk("debug_rsp_quiet", {30'd0, d_rsp_valid, d_rsp_err} | d_rsp_data, 32'd0);
        end
      end
      if ((f_req_valid && f_req_ready) || (d_req_valid && d_req_ready)) begin
        dbg  = d_req_valid && d_req_ready;
        addr = dbg ? d_req_addr : f_req_addr;
        we   = dbg && d_req_we;
`ifdef IMEM_ARB_ALIGN_CHK_EN
        err  = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
`else
        err  = 1'b0;
`endif
        e.dbg  = dbg;
        e.err  = err;
        e.due  = cyc + (err ? 1 : (we ? 5 : 6));
        e.data = (err || we) ? 32'd0 : model_read(addr[7:0]);
        if (we && !err) begin
          for (int k = 0; k < 4; k++) ref_mem[8'(addr[7:0] + 8'(k))] = 8'(d_req_wdata >> (24 - 8 * k));
        end
        sb.push_back(e);
        grants.push_back(dbg);
        acc_cyc = cyc;
      end
    end
  end

  task automatic apply(input vec_t v, input string nm);
    int start;
    bit got;
    int n_exp;
    start = rsp_count;
    got = 0;
    acc_log.delete();
    @(posedge clk); #1;
    if (v.dbg) begin
      d_req_valid = 1'b1; d_req_addr = v.addr; d_req_we = v.we; d_req_wdata = v.wdata;
    end else begin
      f_req_valid = 1'b1; f_req_addr = v.addr;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v.dbg ? d_req_ready : f_req_ready) begin got = 1; break; end
    end
    chk({nm, "_accepted"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_count != start) break;
      @(posedge clk);
    end
    chk({nm, "_rsp_seen"}, {31'd0, rsp_count != start}, 32'd1);
    chk({nm, "_data"}, last_data, v.exp_data);
    chk({nm, "_err"}, {31'd0, last_err}, {31'd0, v.exp_err});
    n_exp = v.exp_err ? 0 : 4;
    chk({nm, "_n_access"}, acc_log.size(), n_exp);
    for (int k = 0; k < acc_log.size() && k < 4; k++) begin
      chk({nm, "_acc_addr"}, {24'd0, acc_log[k].addr}, {24'd0, 8'(v.addr[7:0] + 8'(k))});
      chk({nm, "_acc_kind"}, {31'd0, acc_log[k].we}, {31'd0, v.we});
      chk({nm, "_acc_cycle"}, acc_log[k].cyc, acc_cyc + 1 + k);
      if (v.we) chk({nm, "_acc_wdata"}, {24'd0, acc_log[k].wdata}, {24'd0, 8'(v.wdata >> (24 - 8 * k))});
    end
  endtask

  initial begin
    int t;
    bit drained;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    vecs[0] = '{0, 0, 32'h10,  32'h0,        32'h12345678, 0};
    vecs[1] = '{1, 1, 32'h20,  32'hDEADBEEF, 32'h0,        0};
    vecs[2] = '{0, 0, 32'h20,  32'h0,        32'hDEADBEEF, 0};
    vecs[3] = '{1, 0, 32'h20,  32'h0,        32'hDEADBEEF, 0};
`ifdef IMEM_ARB_ALIGN_CHK_EN
    vecs[4] = '{0, 0, 32'hFE,  32'h0,        32'h0,        1};
    vecs[5] = '{0, 0, 32'h111, 32'h0,        32'h0,        1};
    vecs[6] = '{1, 1, 32'hFF,  32'hA1B2C3D4, 32'h0,        1};
    vecs[7] = '{1, 0, 32'h00,  32'h0,        32'h00010203, 0};
    vecs[8] = '{1, 1, 32'h100, 32'h55667788, 32'h0,        1};
`else
    vecs[4] = '{0, 0, 32'hFE,  32'h0,        32'hFEFF0001, 0};
    vecs[5] = '{0, 0, 32'h111, 32'h0,        32'h34567814, 0};
    vecs[6] = '{1, 1, 32'hFF,  32'hA1B2C3D4, 32'h0,        0};
    vecs[7] = '{1, 0, 32'h00,  32'h0,        32'hB2C3D403, 0};
    vecs[8] = '{0, 0, 32'h100, 32'h0,        32'hB2C3D403, 0};
`endif

    // Reset with both requesters already valid.
    reset = 1'b1;
    f_req_valid = 1'b1; f_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b0; d_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_f_data", f_rsp_data, 32'd0);
    chk("reset_d_data", d_rsp_data, 32'd0);
    chk("reset_flags", {26'd0, f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err, mem_re, mem_we}, 32'd0);
    chk("reset_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Continuous contention: grants must alternate starting with fetch.
    for (t = 0; t < 100; t++) begin
      if (grants.size() >= 4) break;
      @(posedge clk);
    end
    #1;
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    chk("rr_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) chk("rr_grant_order", {31'd0, grants[k]}, 32'(k % 2));
    drained = 0;
    for (t = 0; t < 50; t++) begin
      if (sb.size() == 0) begin drained = 1; break; end
      @(posedge clk);
    end
    chk("rr_drained", {31'd0, drained}, 32'd1);
    chk("rr_first_rsp_fetch", {31'd0, rsp_order.size() > 0 && rsp_order[0] == 1'b0}, 32'd1);

    for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a debug write: no response, partial bytes stay written.
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_we = 1'b1; d_req_wdata = 32'h11223344;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d_req_ready) break;
    end
    chk("abort_accepted", {31'd0, d_req_ready}, 32'd1);
    t = d_rsp_count;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h40;
    @(negedge clk);
    chk("abort_we_low", {31'd0, mem_we}, 32'd0);
    chk("abort_ready_follows", {31'd0, f_req_ready}, 32'd1);
    chk("abort_byte0_kept", {24'd0, mem[8'h80]}, 32'h11);
    chk("abort_byte2_kept", {24'd0, mem[8'h82]}, 32'h33);
    chk("abort_byte3_untouched", {24'd0, mem[8'h83]}, 32'h83);
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    drained = 0;
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) begin drained = 1; break; end
      @(posedge clk);
    end
    chk("abort_fetch_drained", {31'd0, drained}, 32'd1);
    chk("abort_no_d_rsp", d_rsp_count, t);
    chk("abort_fetch_data", last_data, 32'h40414243);
    @(negedge clk);
    chk("idle_no_ready", {30'd0, f_req_ready, d_req_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
